// File: rtl/gpi_filter_pkg.sv
// Shared types and default parameter values for the gpi_filter slice.
package gpi_filter_pkg;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 16;

    typedef enum logic {
        STABLE = 1'b0,
        PEND   = 1'b1
    } state_e;

endpackage

// File: rtl/gpi_filter_if.sv
// Pin-side bundle of the debouncer: raw pad, filtered level, edge pulses and interrupt controls.
interface gpi_filter_if;

    logic gpi_pad;
    logic gpi;
    logic rise;
    logic fall;
    logic irq_rise_en;
    logic irq_fall_en;
    logic irq_clr;
    logic irq;

    // master drives the pad and interrupt controls, slave is the filter itself
    modport master (
        output gpi_pad, irq_rise_en, irq_fall_en, irq_clr,
        input  gpi, rise, fall, irq
    );

    modport slave (
        input  gpi_pad, irq_rise_en, irq_fall_en, irq_clr,
        output gpi, rise, fall, irq
    );

endinterface

// File: rtl/gpi_filter_sync_ff.sv
// Multi-flop synchronizer for one asynchronous input bit; output is the last stage.
module sync_ff #(
    parameter int DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_in,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/gpi_filter.sv
// Synchronizes and debounces a GPIO pad, emits edge pulses and an optional sticky interrupt.
// Define GPI_FILTER_IRQ_EN to build the interrupt flop; otherwise irq_o is tied low.
module gpi_filter
    import gpi_filter_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_in,
    input  logic gpi_pad_i,
    output logic gpi_o,
    output logic rise_o,
    output logic fall_o,
    input  logic irq_rise_en_i,
    input  logic irq_fall_en_i,
    input  logic irq_clr_i,
    output logic irq_o
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gpi_q, gpi_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    sync_ff #(
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_in (rst_in),
        .d_i    (gpi_pad_i),
        .q_o    (sync)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gpi_d   = gpi_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (sync != gpi_q) begin
                    state_d = PEND;
                    cnt_d   = CNT_ONE;
                end
            end
            PEND: begin
                if (sync == gpi_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // enough consecutive disagreeing samples: commit the new level
                    gpi_d   = sync;
                    rise_d  = sync;
                    fall_d  = ~sync;
                    state_d = STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            gpi_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gpi_q   <= gpi_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign gpi_o  = gpi_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

`ifdef GPI_FILTER_IRQ_EN
    logic irq_q;

    // set has priority so an edge landing on the clear cycle is not lost
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            irq_q <= 1'b0;
        end else if ((rise_q & irq_rise_en_i) | (fall_q & irq_fall_en_i)) begin
            irq_q <= 1'b1;
        end else if (irq_clr_i) begin
            irq_q <= 1'b0;
        end
    end

    assign irq_o = irq_q;
`else
    logic unused_irq_inputs;

    assign unused_irq_inputs = irq_rise_en_i ^ irq_fall_en_i ^ irq_clr_i;
    assign irq_o             = 1'b0;
`endif

endmodule

// File: doc/gpi_filter.md
GPI_FILTER -- requirements
Module: gpi_filter

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops (legal range 2..4).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive filtered samples needed to commit a level change (legal range 2..65535).
REQ-003 SHALL have port clk_i, input, 1 bit, sole clock.
REQ-004 SHALL have port rst_in, input, 1 bit, reset, asynchronous, active-low.
REQ-005 SHALL have port gpi_pad_i, input, 1 bit, raw asynchronous pin.
REQ-006 SHALL have port gpi_o, output, 1 bit, debounced level; drives the GPIO slave's gpi_i.
REQ-007 SHALL have port rise_o, output, 1 bit, one-cycle pulse on a committed 0->1 change.
REQ-008 SHALL have port fall_o, output, 1 bit, one-cycle pulse on a committed 1->0 change.
REQ-009 SHALL have port irq_rise_en_i, input, 1 bit, arms the interrupt on rising edges.
REQ-010 SHALL have port irq_fall_en_i, input, 1 bit, arms the interrupt on falling edges.
REQ-011 SHALL have port irq_clr_i, input, 1 bit, clears the sticky interrupt.
REQ-012 SHALL have port irq_o, output, 1 bit, sticky edge interrupt.

Function
REQ-013 gpi_pad_i SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is "sync".
REQ-014 FSM SHALL have two states, STABLE and PEND, plus a counter cnt of width $clog2(DEBOUNCE_CYCLES).
REQ-015 STABLE: sync==gpi_o -> stay, cnt=0; sync!=gpi_o -> PEND, cnt<=1.
REQ-016 PEND: sync==gpi_o -> STABLE, cnt<=0, glitch dropped with no output change.
REQ-017 PEND: sync!=gpi_o and cnt==DEBOUNCE_CYCLES-1 -> gpi_o<=sync, matching rise_o/fall_o high for exactly that next cycle, STABLE, cnt<=0.
REQ-018 PEND: sync!=gpi_o and cnt<DEBOUNCE_CYCLES-1 -> cnt<=cnt+1; cnt SHALL never wrap.
REQ-019 A clean pad step SHALL appear on gpi_o exactly SYNC_STAGES+DEBOUNCE_CYCLES clk_i edges after the first edge that samples it.
REQ-020 A pad pulse shorter than DEBOUNCE_CYCLES sampled cycles SHALL produce no change on gpi_o, rise_o or fall_o.
REQ-021 rise_o and fall_o SHALL be registered, mutually exclusive, and never high on consecutive cycles.
REQ-022 irq_o SHALL set on (rise_o&irq_rise_en_i)|(fall_o&irq_fall_en_i) and clear on irq_clr_i; simultaneous set and clear -> set wins.

Reset
REQ-023 rst_in low SHALL immediately force all sync flops, gpi_o, rise_o, fall_o, irq_o and cnt to 0 and the FSM to STABLE, including mid-PEND.
REQ-024 After rst_in deasserts, a pad held high SHALL produce rise_o after SYNC_STAGES+DEBOUNCE_CYCLES edges.

Configuration
REQ-025 Macro GPI_FILTER_IRQ_EN defined -> REQ-022 logic SHALL be present.
REQ-026 Macro GPI_FILTER_IRQ_EN undefined -> irq_o SHALL be constant 0, irq_* inputs ignored, no irq flop, ports retained.

Structure
REQ-027 Package gpi_filter_pkg SHALL hold the state enum type (STABLE, PEND) and the default parameter constants.
REQ-028 The synchronizer SHALL be a separate sub-module sync_ff, parameterized by depth, async active-low reset.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-029 Pad 0->1 held -> gpi_o=1 exactly 6 edges later; rise_o high 1 cycle; fall_o stays 0.
REQ-030 Pad high for 3 cycles then low -> gpi_o, rise_o, fall_o stay 0 throughout.
REQ-031 Pad chattering 1,0,1 at 1-cycle spacing, then held 1 -> exactly one rise_o, 6 edges after the last 0->1.
REQ-032 irq_rise_en_i=1 with a rise -> irq_o=1 held until irq_clr_i; irq_clr_i coincident with a new rise_o -> irq_o stays 1.
REQ-033 rst_in low while in PEND with cnt=2 -> all outputs 0 immediately; after release a held pad commits after the full 6 edges.
REQ-034 Build without GPI_FILTER_IRQ_EN, rerun REQ-032 -> irq_o constant 0; gpi_o and rise_o unchanged.
